// File: rtl/mux_nx1_rr.sv
// Registered N-input mux: direct select or round-robin arbitration among valid channels.
// Outputs d/dvalid/dsel and the round-robin pointer p update only on enabled edges.
module mux_nx1_rr #(
    parameter int DATAWIDTH = 2,
    parameter int CHANNELS  = 4,
    parameter int SELWIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*DATAWIDTH-1:0] a,
    input  logic [CHANNELS-1:0]           valid,
    input  logic [SELWIDTH-1:0]           sel,
    input  logic                          mode,
    input  logic                          en,
    output logic [DATAWIDTH-1:0]          d,
    output logic                          dvalid,
    output logic [SELWIDTH-1:0]           dsel
);

    logic [DATAWIDTH-1:0] chan [CHANNELS];
    logic [SELWIDTH-1:0]  p;

    logic [DATAWIDTH-1:0] direct_data;
    logic                 direct_valid;

    logic                 hi_found, lo_found;
    logic [SELWIDTH-1:0]  hi_win, lo_win;
    logic [DATAWIDTH-1:0] hi_data, lo_data;

    logic                 rr_found;
    logic [SELWIDTH-1:0]  rr_win;
    logic [DATAWIDTH-1:0] rr_data;
    logic [SELWIDTH-1:0]  p_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan[i] = a[i*DATAWIDTH +: DATAWIDTH];
    end

    // Out-of-range selects (non-power-of-2 CHANNELS) fall through to zero data, invalid.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        direct_data  = '0;
        direct_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELWIDTH'(i)) begin
                direct_data  = chan[i];
                direct_valid = valid[i];
            end
        end
    end

    // Search p..CHANNELS-1 first, then 0..p-1: the circular order without any modulo hardware.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        hi_data  = '0;
        lo_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (valid[k]) begin
                if (SELWIDTH'(k) >= p) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_win   = SELWIDTH'(k);
                        hi_data  = chan[k];
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_win   = SELWIDTH'(k);
                    lo_data  = chan[k];
                end
            end
        end
    end

    always_comb begin
        rr_found = hi_found | lo_found;
        rr_win   = hi_found ? hi_win  : lo_win;
        rr_data  = hi_found ? hi_data : lo_data;
        // Exact wrap at CHANNELS-1 rather than letting SELWIDTH bits overflow.
        p_next   = (rr_win == SELWIDTH'(CHANNELS - 1)) ? '0 : rr_win + SELWIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d      <= '0;
            dvalid <= 1'b0;
            dsel   <= '0;
            p      <= '0;
        end else if (en) begin
            if (!mode) begin
                d      <= direct_data;
                dvalid <= direct_valid;
                dsel   <= sel;
            end else if (rr_found) begin
                d      <= rr_data;
                dvalid <= 1'b1;
                dsel   <= rr_win;
                p      <= p_next;
            end else begin
                dvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: a 4-channel and a 3-channel instance, table vectors,
// hand-written corner sequences and a randomized run against a behavioural model.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] a4;
    logic [3:0]  v4;
    logic [1:0]  sel4;
    logic        mode4, en4;
    logic [7:0]  d4;
    logic        dv4;
    logic [1:0]  dsel4;

    logic [23:0] a3;
    logic [2:0]  v3;
    logic [1:0]  sel3;
    logic        mode3, en3;
    logic [7:0]  d3;
    logic        dv3;
    logic [1:0]  dsel3;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = 4-channel DUT, index 1 = 3-channel DUT.
    int          m_p    [2];
    logic [7:0]  m_d    [2];
    logic        m_dv   [2];
    logic [1:0]  m_dsel [2];

    typedef struct {
        logic       mode;
        logic       en;
        logic [3:0] valid;
        logic [1:0] sel;
        logic [7:0] exp_d;
        logic       exp_dv;
        logic [1:0] exp_dsel;
    } vec_t;

    vec_t vecs [17];

    mux_nx1_rr #(.DATAWIDTH(8), .CHANNELS(4), .SELWIDTH(2)) u4 (
        .clk(clk), .rst(rst), .a(a4), .valid(v4), .sel(sel4), .mode(mode4), .en(en4),
        .d(d4), .dvalid(dv4), .dsel(dsel4)
    );

    mux_nx1_rr #(.DATAWIDTH(8), .CHANNELS(3), .SELWIDTH(2)) u3 (
        .clk(clk), .rst(rst), .a(a3), .valid(v3), .sel(sel3), .mode(mode3), .en(en3),
        .d(d3), .dvalid(dv3), .dsel(dsel3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_p[u] = 0; m_d[u] = '0; m_dv[u] = 1'b0; m_dsel[u] = '0;
        end
    endtask

    // Behavioural rule set: circular search with plain modulo arithmetic.
    task automatic model_step(input int u, input int ch, input logic [31:0] a,
                              input logic [3:0] v, input logic [1:0] s,
                              input logic mode, input logic en);
        int  k;
        bit  found;
        if (!en) return;
        if (!mode) begin
            if (int'(s) < ch) begin
                m_d[u]  = a[8*s +: 8];
                m_dv[u] = v[s];
            end else begin
                m_d[u]  = '0;
                m_dv[u] = 1'b0;
            end
            m_dsel[u] = s;
        end else begin
            found = 0;
            for (int off = 0; off < ch; off++) begin
                k = (m_p[u] + off) % ch;
                if (!found && v[k]) begin
                    found     = 1;
                    m_d[u]    = a[8*k +: 8];
                    m_dsel[u] = 2'(k);
                    m_dv[u]   = 1'b1;
                    m_p[u]    = (k + 1) % ch;
                end
            end
            if (!found) m_dv[u] = 1'b0;
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_d4"},    32'(d4),    32'(m_d[0]));
        check({tag, "_dv4"},   32'(dv4),   32'(m_dv[0]));
        check({tag, "_dsel4"}, 32'(dsel4), 32'(m_dsel[0]));
        check({tag, "_d3"},    32'(d3),    32'(m_d[1]));
        check({tag, "_dv3"},   32'(dv3),   32'(m_dv[1]));
        check({tag, "_dsel3"}, 32'(dsel3), 32'(m_dsel[1]));
    endtask

    task automatic set3(input logic mode, input logic en, input logic [2:0] v, input logic [1:0] s);
        mode3 = mode; en3 = en; v3 = v; sel3 = s;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'b1011, 2'd2, 8'h33, 1'b0, 2'd2};
        vecs[1]  = '{1'b0, 1'b1, 4'b1011, 2'd3, 8'h44, 1'b1, 2'd3};
        vecs[2]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h11, 1'b1, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h22, 1'b1, 2'd1};
        vecs[4]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h33, 1'b1, 2'd2};
        vecs[5]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h44, 1'b1, 2'd3};
        vecs[6]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h11, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 4'b0000, 2'd0, 8'h11, 1'b1, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 4'b1010, 2'd3, 8'h11, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 4'b0101, 2'd2, 8'h11, 1'b1, 2'd0};
        vecs[10] = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h22, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 1'b1, 4'b0000, 2'd0, 8'h22, 1'b0, 2'd1};
        vecs[12] = '{1'b1, 1'b1, 4'b0101, 2'd0, 8'h33, 1'b1, 2'd2};
        vecs[13] = '{1'b1, 1'b1, 4'b0101, 2'd0, 8'h11, 1'b1, 2'd0};
        vecs[14] = '{1'b1, 1'b1, 4'b0101, 2'd0, 8'h33, 1'b1, 2'd2};
        vecs[15] = '{1'b0, 1'b1, 4'b0010, 2'd1, 8'h22, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 1'b1, 4'b1111, 2'd0, 8'h44, 1'b1, 2'd3};

        rst = 1'b1;
        a4 = 32'h44332211; v4 = '0; sel4 = '0; mode4 = 1'b0; en4 = 1'b0;
        a3 = 24'hCCBBAA;   v3 = '0; sel3 = '0; mode3 = 1'b0; en3 = 1'b0;
        #1;
        check("por_d4", 32'(d4), 32'h0);
        check("por_dv4", 32'(dv4), 32'h0);
        check("por_dsel4", 32'(dsel4), 32'h0);
        repeat (2) cycle();
        rst = 1'b0;

        // Table vectors on the 4-channel instance.
        for (int i = 0; i < 17; i++) begin
            mode4 = vecs[i].mode; en4 = vecs[i].en; v4 = vecs[i].valid; sel4 = vecs[i].sel;
            cycle();
            check($sformatf("vec%0d_d", i),    32'(d4),    32'(vecs[i].exp_d));
            check($sformatf("vec%0d_dv", i),   32'(dv4),   32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_dsel", i), 32'(dsel4), 32'(vecs[i].exp_dsel));
        end
        en4 = 1'b0;

        // 3-channel: out-of-range select, then round-robin wrap from p=2 back to 0.
        set3(1'b0, 1'b1, 3'b111, 2'd3);
        cycle();
        check("ch3_oor_d", 32'(d3), 32'h0);
        check("ch3_oor_dv", 32'(dv3), 32'h0);
        check("ch3_oor_dsel", 32'(dsel3), 32'd3);
        set3(1'b1, 1'b1, 3'b011, 2'd0);
        cycle();
        check("ch3_rr0_dsel", 32'(dsel3), 32'd0);
        set3(1'b1, 1'b1, 3'b010, 2'd0);
        cycle();
        check("ch3_rr1_dsel", 32'(dsel3), 32'd1);
        set3(1'b1, 1'b1, 3'b100, 2'd0);
        cycle();
        check("ch3_rr2_dsel", 32'(dsel3), 32'd2);
        check("ch3_rr2_d", 32'(d3), 32'hCC);
        set3(1'b1, 1'b1, 3'b111, 2'd0);
        cycle();
        check("ch3_wrap_dsel", 32'(dsel3), 32'd0);
        check("ch3_wrap_d", 32'(d3), 32'hAA);
        set3(1'b1, 1'b1, 3'b111, 2'd0);
        cycle();
        check("ch3_next_dsel", 32'(dsel3), 32'd1);

        // Move the 4-channel pointer off zero, then reset between edges.
        mode4 = 1'b1; en4 = 1'b1; v4 = 4'b0100;
        cycle();
        check("pre_rst_dsel4", 32'(dsel4), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_d4", 32'(d4), 32'h0);
        check("async_rst_dv4", 32'(dv4), 32'h0);
        check("async_rst_dsel4", 32'(dsel4), 32'h0);
        check("async_rst_d3", 32'(d3), 32'h0);
        check("async_rst_dv3", 32'(dv3), 32'h0);
        cycle();
        rst = 1'b0;
        model_reset();
        mode4 = 1'b1; en4 = 1'b1; v4 = 4'b1111;
        set3(1'b1, 1'b1, 3'b111, 2'd0);
        model_step(0, 4, a4, v4, sel4, mode4, en4);
        model_step(1, 3, {8'h0, a3}, {1'b0, v3}, sel3, mode3, en3);
        cycle();
        check("post_rst_dsel4", 32'(dsel4), 32'd0);
        check("post_rst_dsel3", 32'(dsel3), 32'd0);
        check_both("post_rst");

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            a4    = $urandom;
            v4    = 4'($urandom_range(0, 15));
            sel4  = 2'($urandom_range(0, 3));
            mode4 = ($urandom_range(0, 3) != 0);
            en4   = ($urandom_range(0, 4) != 0);
            a3    = 24'($urandom);
            v3    = 3'($urandom_range(0, 7));
            sel3  = 2'($urandom_range(0, 3));
            mode3 = ($urandom_range(0, 3) != 0);
            en3   = ($urandom_range(0, 4) != 0);
            model_step(0, 4, a4, v4, sel4, mode4, en4);
            model_step(1, 3, {8'h0, a3}, {1'b0, v3}, sel3, mode3, en3);
            cycle();
            check_both($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
